dds_phase_acc: RTL and testbench

Phase accumulator for the DDS synthesizer; produces the `phase` word consumed by the waveform shapers (triangle, saw, square, sine LUT). On each sample tick it adds a frequency control word (FCW), modulo 2^N, to the accumulator. A prescaler sets the tick rate. New FCWs arrive over a valid/ready handshake and are applied either on the next tick or phase-continuously at the next wrap.

---
 rtl/dds_phase_acc.sv | 105 ++++++++++
 tb/tb_dds_phase_acc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator: on each prescaled tick it adds the frequency control word to the phase.
// A new FCW is taken over valid/ready and applies on the next tick, or at the next wrap if fcw_sync was set.
module dds_phase_acc #(
  parameter int N = 14,
  parameter int F = 14,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [P-1:0] prescale,
  input  logic [F-1:0] fcw_data,
  input  logic         fcw_sync,
  input  logic         fcw_valid,
  output logic         fcw_ready,
  output logic [N-1:0] phase,
  output logic         phase_valid,
  output logic         wrap,
  output logic         pend,
  output logic         dbg_state
);

  // Handshake: an FCW transfers on a clk edge where fcw_valid && fcw_ready.
  // fcw_ready is high only in IDLE. While PENDING, fcw_valid is ignored, so the source must hold its word.
  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_e;

  state_e       state_q;
  logic [N-1:0] phase_q;
  logic [P-1:0] cnt_q, cnt_d;
  logic [F-1:0] fcw_active_q, fcw_pend_q;
  logic         sync_pend_q;
  logic         phase_valid_q, wrap_q;

  logic         tick, tick_eff;
  logic [F-1:0] addend;
  logic [N:0]   sum;
  logic         carry;

  always_comb begin
    tick     = en && (cnt_q == prescale);
    tick_eff = tick && !clr;
    // A mode-0 pending word takes effect on the tick that applies it.
    // A sync-mode pending word keeps the old word in use until it carries.
    addend = fcw_active_q;
    if (state_q == ST_PENDING && !sync_pend_q) addend = fcw_pend_q;
    sum   = {1'b0, phase_q} + {{(N + 1 - F){1'b0}}, addend};
    carry = sum[N];
    cnt_d = cnt_q;
    if (clr || tick) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      cnt_q         <= '0;
      fcw_active_q  <= '0;
      fcw_pend_q    <= '0;
      sync_pend_q   <= 1'b0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (clr) begin
        phase_q       <= '0;
        phase_valid_q <= 1'b0;
        wrap_q        <= 1'b0;
      end else if (tick) begin
        phase_q       <= sum[N-1:0];
        phase_valid_q <= 1'b1;
        wrap_q        <= carry;
      end else begin
        phase_valid_q <= 1'b0;
        wrap_q        <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (fcw_valid) begin
            fcw_pend_q  <= fcw_data;
            sync_pend_q <= fcw_sync;
            state_q     <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (tick_eff && (!sync_pend_q || carry)) begin
            fcw_active_q <= fcw_pend_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fcw_ready   = (state_q == ST_IDLE);
  assign pend        = (state_q == ST_PENDING);
  assign dbg_state   = state_q;
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// Directed bench for dds_phase_acc: expected {wrap, phase} pairs are queued as ticks are provoked.
// Each phase_valid pulse pops and compares one pair; handshake and hold behaviour are checked inline.
module tb_dds_phase_acc;
  localparam int N = 14;
  localparam int F = 14;
  localparam int P = 8;
  localparam int W = N + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic [P-1:0] prescale;
  logic [F-1:0] fcw_data;
  logic         fcw_sync;
  logic         fcw_valid;
  logic         fcw_ready;
  logic [N-1:0] phase;
  logic         phase_valid;
  logic         wrap;
  logic         pend;
  logic         dbg_state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  dds_phase_acc #(.N(N), .F(F), .P(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .prescale(prescale),
    .fcw_data(fcw_data), .fcw_sync(fcw_sync), .fcw_valid(fcw_valid),
    .fcw_ready(fcw_ready), .phase(phase), .phase_valid(phase_valid),
    .wrap(wrap), .pend(pend), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Driver tasks
  task automatic push_exp(input logic w, input logic [N-1:0] p);
    exp_q.push_back({w, p});
  endtask

  task automatic load_fcw(input logic [F-1:0] d, input logic s);
    fcw_data  = d;
    fcw_sync  = s;
    fcw_valid = 1'b1;
    cyc(1);
    fcw_valid = 1'b0;
  endtask

  // Scoreboard: every phase_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n === 1'b1 && phase_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_pulse observed=0x%0h expected=none", {wrap, phase});
      end else begin
        e = exp_q.pop_front();
        assert ({wrap, phase} === e) else begin
          bad++;
          $error("FAIL pulse_wrap_phase observed=0x%0h expected=0x%0h", {wrap, phase}, e);
        end
      end
    end
  end

  initial begin
    int pulses;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; prescale = '0;
    fcw_data = 14'h1234; fcw_sync = 1'b0; fcw_valid = 1'b1;

    // Reset held 3 cycles with an FCW offered
    cyc(3);
    chk("rst_phase", phase, 0);
    chk("rst_phase_valid", phase_valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_pend", pend, 0);
    rst_n = 1'b1; fcw_valid = 1'b0;
    chk("rst_ready", fcw_ready, 1);

    // Basic accumulate, FCW 0x1000 mode 0, tick every cycle
    load_fcw(14'h1000, 1'b0);
    chk("basic_pend", pend, 1);
    chk("basic_ready_low", fcw_ready, 0);
    push_exp(0, 14'h1000); push_exp(0, 14'h2000); push_exp(0, 14'h3000); push_exp(1, 14'h0000);
    en = 1'b1;
    cyc(1);
    chk("basic_first_phase", phase, 14'h1000);
    chk("basic_pend_fall", pend, 0);
    chk("basic_ready_back", fcw_ready, 1);
    cyc(3);
    chk("basic_wrap_phase", phase, 0);
    chk("basic_wrap_flag", wrap, 1);
    en = 1'b0;

    // Prescaler = 3, FCW 0x0010: pulse on every 4th cycle
    load_fcw(14'h0010, 1'b0);
    prescale = 8'd3; en = 1'b1;
    push_exp(0, 14'h0010); push_exp(0, 14'h0020); push_exp(0, 14'h0030);
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      chk($sformatf("presc_pulse_c%0d", i), phase_valid, (i % 4 == 0) ? 1 : 0);
    end
    en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (phase_valid) pulses++;
    end
    chk("en_low_pulses", pulses, 0);
    chk("en_low_phase", phase, 14'h0030);

    // Sync update: run at 0x1000, offer 0x0800 sync-mode at phase 0x1000
    prescale = 8'd0;
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clr_phase", phase, 0);
    load_fcw(14'h1000, 1'b0);
    push_exp(0, 14'h1000); push_exp(0, 14'h2000); push_exp(0, 14'h3000);
    push_exp(1, 14'h0000); push_exp(0, 14'h0800); push_exp(0, 14'h1000);
    en = 1'b1;
    cyc(1);
    fcw_data = 14'h0800; fcw_sync = 1'b1; fcw_valid = 1'b1;
    cyc(1);
    fcw_valid = 1'b0;
    chk("sync_accept_old_fcw", phase, 14'h2000);
    chk("sync_pend", pend, 1);
    cyc(1);
    chk("sync_pend_hold", pend, 1);
    cyc(1);
    chk("sync_wrap", wrap, 1);
    chk("sync_pend_fall", pend, 0);
    cyc(2);
    chk("sync_new_fcw", phase, 14'h1000);
    en = 1'b0;

    // Accept coincident with a tick in mode 0: that tick uses 0x0800
    push_exp(0, 14'h1800); push_exp(0, 14'h1900); push_exp(0, 14'h1A00);
    en = 1'b1;
    load_fcw(14'h0100, 1'b0);
    chk("coll_old_fcw", phase, 14'h1800);
    chk("coll_pend", pend, 1);
    cyc(1);
    chk("coll_pend_fall", pend, 0);
    cyc(1);
    en = 1'b0;

    // clr coincident with a tick, mode-0 word pending
    load_fcw(14'h0200, 1'b0);
    en = 1'b1; clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_tick_phase", phase, 0);
    chk("clr_tick_valid", phase_valid, 0);
    chk("clr_tick_pend", pend, 1);
    push_exp(0, 14'h0200); push_exp(0, 14'h0400);
    cyc(2);
    chk("clr_then_apply", phase, 14'h0400);
    en = 1'b0;

    // Prescale lowered below cnt: counter runs through 2^P before ticking
    prescale = 8'd3; en = 1'b1;
    cyc(2);
    prescale = 8'd1;
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      cyc(1);
      if (phase_valid) pulses++;
    end
    chk("lowered_presc_no_tick", pulses, 0);
    push_exp(0, 14'h0600);
    cyc(1);
    chk("lowered_presc_tick", phase_valid, 1);
    en = 1'b0;

    // Reset mid-handshake discards the pending word
    load_fcw(14'h0123, 1'b1);
    chk("pre_rst_pend", pend, 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("rst_discard_pend", pend, 0);
    chk("rst_discard_phase", phase, 0);

    cyc(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
